// File: rtl/regfile_param_bypass.sv
// -----------------------------------------------------------------------------
// regfile_param_bypass
//
// Integer register file for the decode/operand-fetch stage.
//   - One write port and NREAD combinational read ports.
//   - x0 always reads as zero and ignores writes and issues.
//   - Optional same-cycle write-to-read forwarding (BYPASS = 1).
//   - One busy bit per register, tracking in-flight producers.
//   - The storage array has no reset, so it can map to distributed RAM.
//     A clear sequencer zeroes it one entry per cycle after reset or on
//     request. Reads, writes and issues are accepted only once the sweep
//     has finished.
//
// Parameters:
//   XLEN   register width in bits
//   NREGS  number of architectural registers (power of two, >= 2)
//   NREAD  number of read ports (>= 1)
//   BYPASS 1 = forward same-cycle write data to matching reads, 0 = none
//
// Ports:
//   clk_i         clock, all state changes on the rising edge
//   rst_i         asynchronous active-high reset
//   clear_i       single-cycle request to re-zero the whole file
//   ready_o       file is out of the clear sweep and accepting traffic
//   write_en_i    write strobe
//   write_addr_i  write register index
//   write_data_i  write data
//   issue_en_i    mark issue_addr_i as having an in-flight producer
//   issue_addr_i  destination register of the issued instruction
//   read_addr_i   packed read indices, port k at [k*AW +: AW]
//   read_data_o   packed read data, port k at [k*XLEN +: XLEN]
//   read_busy_o   per port: addressed register has a pending producer
// -----------------------------------------------------------------------------
module regfile_param_bypass #(
    parameter int XLEN   = 64,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           clear_i,
    output logic                           ready_o,
    input  logic                           write_en_i,
    input  logic [$clog2(NREGS)-1:0]       write_addr_i,
    input  logic [XLEN-1:0]                write_data_i,
    input  logic                           issue_en_i,
    input  logic [$clog2(NREGS)-1:0]       issue_addr_i,
    input  logic [NREAD*$clog2(NREGS)-1:0] read_addr_i,
    output logic [NREAD*XLEN-1:0]          read_data_o,
    output logic [NREAD-1:0]               read_busy_o
);

    localparam int AW = $clog2(NREGS);

    // clr_cnt carries one extra bit so it never wraps before the last entry.
    localparam logic [AW:0] CLR_LAST = (AW+1)'(NREGS - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t            state;
    logic [AW:0]       clr_cnt;
    logic [NREGS-1:0]  busy;
    logic [XLEN-1:0]   mem [NREGS];

    logic              accept;
    logic              wr_ok;
    logic              iss_ok;

    // A clear request in READY takes priority: a write or issue in the
    // same cycle is dropped.
    assign accept  = (state == ST_READY) && !clear_i;
    assign wr_ok   = accept && write_en_i && (write_addr_i != '0);
    assign iss_ok  = accept && issue_en_i && (issue_addr_i != '0);

    assign ready_o = (state == ST_READY);

    // -------------------------------------------------------------------------
    // Control: sweep sequencer and busy scoreboard
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
            busy    <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST) begin
                        state <= ST_READY;
                    end
                end
                ST_READY: begin
                    if (clear_i) begin
                        state   <= ST_CLEAR;
                        clr_cnt <= '0;
                        busy    <= '0;
                    end else begin
                        if (wr_ok) begin
                            busy[write_addr_i] <= 1'b0;
                        end
                        // Issued after the write clear so that a same-cycle
                        // issue to the same register leaves it busy.
                        if (iss_ok) begin
                            busy[issue_addr_i] <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= ST_CLEAR;
                    clr_cnt <= '0;
                    busy    <= '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Storage: no reset, single write port shared by the sweep and writes
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (state == ST_CLEAR) begin
            mem[clr_cnt[AW-1:0]] <= '0;
        end else if (wr_ok) begin
            mem[write_addr_i] <= write_data_i;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational read ports
    // -------------------------------------------------------------------------
    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   ra;
        logic            fwd;
        logic [XLEN-1:0] rd;
        logic            rb;

        assign ra  = read_addr_i[k*AW +: AW];
        assign fwd = (BYPASS != 0) && write_en_i && (write_addr_i == ra);

        // Everything reads as zero and idle until the sweep completes, so
        // the undefined array contents are never observable.
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if ((state == ST_READY) && (ra != '0)) begin
                rd = fwd ? write_data_i : mem[ra];
                // A forwarded write satisfies the pending producer now.
                rb = busy[ra] && !fwd;
            end
        end

        assign read_data_o[k*XLEN +: XLEN] = rd;
        assign read_busy_o[k]              = rb;
    end

endmodule

// File: tb/tb_regfile_param_bypass.sv
module tb_regfile_param_bypass;

    localparam int XLEN  = 64;
    localparam int NREGS = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  clear;
    logic                  write_en;
    logic [AW-1:0]         write_addr;
    logic [XLEN-1:0]       write_data;
    logic                  issue_en;
    logic [AW-1:0]         issue_addr;
    logic [AW-1:0]         ra [NREAD];
    logic [NREAD*AW-1:0]   read_addr;

    logic                  ready_b, ready_n;
    logic [NREAD*XLEN-1:0] rdata_b, rdata_n;
    logic [NREAD-1:0]      rbusy_b, rbusy_n;

    int checks   = 0;
    int failures = 0;

    // Reference state: architectural contents, producers, and sweep progress.
    logic [XLEN-1:0] m_mem  [NREGS];
    bit              m_busy [NREGS];
    bit              m_ready;
    int              m_clr_left;

    assign read_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_param_bypass #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(1)) u_dut_byp (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(ready_b),
        .write_en_i(write_en), .write_addr_i(write_addr), .write_data_i(write_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .read_addr_i(read_addr), .read_data_o(rdata_b), .read_busy_o(rbusy_b)
    );

    regfile_param_bypass #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .BYPASS(0)) u_dut_nb (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .ready_o(ready_n),
        .write_en_i(write_en), .write_addr_i(write_addr), .write_data_i(write_data),
        .issue_en_i(issue_en), .issue_addr_i(issue_addr),
        .read_addr_i(read_addr), .read_data_o(rdata_n), .read_busy_o(rbusy_n)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_ready    = 1'b0;
        m_clr_left = NREGS;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
    endtask

    // Apply one rising edge to the reference, using the inputs as driven.
    task automatic m_edge();
        if (rst) begin
            m_reset();
        end else if (!m_ready) begin
            m_clr_left--;
            if (m_clr_left == 0) begin
                foreach (m_mem[i]) m_mem[i] = '0;
                m_ready = 1'b1;
            end
        end else if (clear) begin
            m_ready    = 1'b0;
            m_clr_left = NREGS;
            foreach (m_busy[i]) m_busy[i] = 1'b0;
        end else begin
            if (write_en && write_addr != 0) begin
                m_mem[write_addr]  = write_data;
                m_busy[write_addr] = 1'b0;
            end
            if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    function automatic logic [XLEN-1:0] exp_data(input int a, input bit byp);
        if (!m_ready || a == 0) return '0;
        if (byp && write_en && write_addr == a) return write_data;
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input int a, input bit byp);
        if (!m_ready || a == 0) return 1'b0;
        if (byp && write_en && write_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    task automatic check_outputs();
        chk("ready_byp", 64'(ready_b), 64'(m_ready));
        chk("ready_nb",  64'(ready_n), 64'(m_ready));
        for (int k = 0; k < NREAD; k++) begin
            chk($sformatf("rdata_byp[%0d] x%0d", k, ra[k]), rdata_b[k*XLEN +: XLEN], exp_data(ra[k], 1'b1));
            chk($sformatf("rdata_nb[%0d] x%0d",  k, ra[k]), rdata_n[k*XLEN +: XLEN], exp_data(ra[k], 1'b0));
            chk($sformatf("rbusy_byp[%0d] x%0d", k, ra[k]), 64'(rbusy_b[k]), 64'(exp_busy(ra[k], 1'b1)));
            chk($sformatf("rbusy_nb[%0d] x%0d",  k, ra[k]), 64'(rbusy_n[k]), 64'(exp_busy(ra[k], 1'b0)));
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic idle();
        clear      = 1'b0;
        write_en   = 1'b0;
        write_addr = '0;
        write_data = '0;
        issue_en   = 1'b0;
        issue_addr = '0;
    endtask

    task automatic rand_inputs(input bit allow_clear);
        write_en   = 1'($urandom_range(0, 1));
        write_addr = AW'($urandom_range(0, NREGS - 1));
        write_data = {$urandom, $urandom};
        issue_en   = 1'($urandom_range(0, 1));
        issue_addr = AW'($urandom_range(0, NREGS - 1));
        ra[0]      = AW'($urandom_range(0, NREGS - 1));
        ra[1]      = ($urandom_range(0, 3) == 0) ? write_addr : AW'($urandom_range(0, NREGS - 1));
        clear      = allow_clear && ($urandom_range(0, 63) == 0);
    endtask

    // Runs until ready_o rises (bounded) and reports the number of low cycles.
    task automatic sweep_wait(output int n);
        n = 0;
        while (ready_b !== 1'b1 && n < 100) begin
            rand_inputs(1'b1);
            tick();
            n++;
        end
        idle();
    endtask

    initial begin
        int n;
        rst = 1'b1;
        idle();
        ra[0] = '0;
        ra[1] = '0;
        foreach (m_mem[i]) m_mem[i] = '0;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        chk("reset_ready", 64'(ready_b), 64'd0);

        // Initial sweep with ignored traffic
        rst = 1'b0;
        sweep_wait(n);
        chk("sweep_len_reset", 64'(n), 64'(NREGS));

        // Every register reads zero after the sweep
        for (int i = 0; i < NREGS; i++) begin
            ra[0] = AW'(i);
            ra[1] = AW'(NREGS - 1 - i);
            #1;
            chk("zero_after_sweep", rdata_b[XLEN-1:0], 64'd0);
            tick();
        end

        // Write x5, read it on both ports the next cycle
        write_en = 1'b1; write_addr = 5; write_data = 64'hDEAD_BEEF_0123_4567;
        ra[0] = 0; ra[1] = 0;
        tick();
        idle();
        ra[0] = 5; ra[1] = 5;
        #1;
        chk("x5_port0", rdata_n[XLEN-1:0],    64'hDEAD_BEEF_0123_4567);
        chk("x5_port1", rdata_n[2*XLEN-1:XLEN], 64'hDEAD_BEEF_0123_4567);
        tick();

        // Write to x0 is discarded
        write_en = 1'b1; write_addr = 0; write_data = '1;
        ra[0] = 0; ra[1] = 0;
        tick();
        idle();
        #1;
        chk("x0_reads_zero", rdata_b[XLEN-1:0], 64'd0);
        tick();

        // Bypass versus no bypass
        write_en = 1'b1; write_addr = 7; write_data = 64'h22;
        tick();
        write_en = 1'b1; write_addr = 7; write_data = 64'h11;
        ra[1] = 7;
        #1;
        chk("bypass_same_cycle", rdata_b[2*XLEN-1:XLEN], 64'h11);
        chk("nobypass_old",      rdata_n[2*XLEN-1:XLEN], 64'h22);
        tick();
        idle();
        #1;
        chk("nobypass_next", rdata_n[2*XLEN-1:XLEN], 64'h11);
        tick();

        // Scoreboard
        issue_en = 1'b1; issue_addr = 3; ra[0] = 3;
        #1;
        chk("issue_same_cycle_not_busy", 64'(rbusy_b[0]), 64'd0);
        tick();
        idle();
        #1;
        chk("issue_busy_next", 64'(rbusy_n[0]), 64'd1);
        issue_en = 1'b1; issue_addr = 3;
        write_en = 1'b1; write_addr = 3; write_data = 64'h33;
        #1;
        chk("write_forces_idle_byp", 64'(rbusy_b[0]), 64'd0);
        chk("write_no_force_nb",     64'(rbusy_n[0]), 64'd1);
        tick();
        idle();
        #1;
        chk("set_wins", 64'(rbusy_b[0]), 64'd1);
        tick();
        write_en = 1'b1; write_addr = 3; write_data = 64'h44;
        tick();
        idle();
        #1;
        chk("write_clears_busy", 64'(rbusy_n[0]), 64'd0);
        issue_en = 1'b1; issue_addr = 0; ra[0] = 0;
        tick();
        idle();
        #1;
        chk("x0_never_busy", 64'(rbusy_n[0]), 64'd0);
        tick();

        // Randomized traffic, occasional clears
        for (int i = 0; i < 400; i++) begin
            rand_inputs(1'b1);
            tick();
        end
        idle();
        sweep_wait(n);

        // Clear request after filling x1..x31
        for (int i = 1; i < NREGS; i++) begin
            write_en = 1'b1; write_addr = AW'(i); write_data = XLEN'(i);
            issue_en = 1'b1; issue_addr = AW'(NREGS - i);
            tick();
        end
        idle();
        ra[0] = 9; ra[1] = 20;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        #1;
        chk("clear_drops_ready", 64'(ready_b), 64'd0);
        sweep_wait(n);
        chk("sweep_len_clear", 64'(n), 64'(NREGS));
        for (int i = 0; i < NREGS; i++) begin
            ra[0] = AW'(i);
            ra[1] = AW'(i);
            #1;
            chk("zero_after_clear", rdata_b[XLEN-1:0], 64'd0);
            chk("idle_after_clear", 64'(rbusy_n[0]), 64'd0);
            tick();
        end

        // Reset mid-sweep at clr_cnt = 10
        clear = 1'b1;
        tick();
        idle();
        repeat (10) tick();
        rst = 1'b1;
        #2;
        m_reset();
        check_outputs();
        tick();
        rst = 1'b0;
        sweep_wait(n);
        chk("sweep_len_midreset", 64'(n), 64'(NREGS));

        // Reset during operation with a busy register
        issue_en = 1'b1; issue_addr = 9;
        write_en = 1'b1; write_addr = 9; write_data = 64'h99;
        tick();
        idle();
        ra[0] = 9; ra[1] = 9;
        #1;
        chk("busy_before_reset", 64'(rbusy_b[0]), 64'd1);
        rst = 1'b1;
        #2;
        m_reset();
        chk("async_reset_ready", 64'(ready_b), 64'd0);
        chk("async_reset_busy",  64'(rbusy_b[0]), 64'd0);
        chk("async_reset_data",  rdata_n[XLEN-1:0], 64'd0);
        check_outputs();
        tick();
        rst = 1'b0;
        sweep_wait(n);
        chk("sweep_len_opreset", 64'(n), 64'(NREGS));
        ra[0] = 9;
        #1;
        chk("data_zero_after_reset", rdata_b[XLEN-1:0], 64'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_param_bypass.md
# regfile_param_bypass

Parametrised integer register file for the core's decode/operand-fetch stage: one write port, NREAD combinational read ports, x0 hard-wired to zero, optional write-to-read bypass, and a per-register busy scoreboard for in-flight producers. The storage array has no reset and maps to distributed RAM. An internal clear sequencer zeroes it one entry per cycle after reset or on request.

## Interface
- XLEN, 64: register data width in bits.
- NREGS, 32: number of architectural registers. Power of two, at least 2.
- NREAD, 2: number of read ports, at least 1.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching reads; 0 = no forwarding.
- AW (localparam) = $clog2(NREGS).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- clear_i  in  1  single-cycle request to re-zero the whole file.
- ready_o  out  1  high when the file is accepting reads, writes and issues.
- write_en_i  in  1  write strobe.
- write_addr_i  in  AW  write register index.
- write_data_i  in  XLEN  write data.
- issue_en_i  in  1  marks issue_addr_i as having an in-flight producer.
- issue_addr_i  in  AW  destination register of the issued instruction.
- read_addr_i  in  NREAD*AW  packed read indices; port k uses bits [k*AW +: AW].
- read_data_o  out  NREAD*XLEN  packed read data; port k uses bits [k*XLEN +: XLEN].
- read_busy_o  out  NREAD  per port: the addressed register has a pending producer.

## Operation
- FSM states are CLEAR and READY.
  - rst_i asserted: the FSM is forced to CLEAR, clr_cnt = 0, and all busy bits are 0.
- CLEAR state:
  - Each cycle, write 0 to array[clr_cnt], then increment clr_cnt.
  - When clr_cnt = NREGS-1 has been written, go to READY.
  - While in CLEAR: ready_o = 0, read_data_o = 0, read_busy_o = 0.
  - While in CLEAR, write_en_i, issue_en_i and clear_i are ignored.
- READY state:
  - ready_o = 1.
  - clear_i = 1: go to CLEAR with clr_cnt = 0 and clear all busy bits. A write or issue in the same cycle is dropped.
- Write (READY, write_en_i = 1, write_addr_i != 0): array[write_addr_i] is updated at the clock edge. Writes to address 0 are discarded.
- Read, per port k with address a:
  - a = 0: data = 0.
  - BYPASS = 1 and write_en_i = 1 and write_addr_i = a: data = write_data_i.
  - Otherwise: data = array[a].
- Scoreboard, one busy bit per register; bit 0 is constant 0.
  - A write to a clears busy[a].
  - issue_en_i with issue_addr_i = a sets busy[a].
  - If issue and write target the same a in the same cycle, set wins (busy[a] = 1 afterwards).
  - Issue to address 0 is ignored.
- read_busy_o[k]:
  - Equals busy[a], except that a write to a in the same cycle forces it to 0 when BYPASS = 1.
  - A same-cycle issue does not affect read_busy_o in that cycle.
- No reset on the array contents; the array is defined only through the clear sweep.

## Timing
- Reset values:
  - ready_o = 0, read_data_o = 0, read_busy_o = 0.
  - FSM = CLEAR, clr_cnt = 0, busy = 0.
- After rst_i deasserts, CLEAR lasts exactly NREGS rising edges. ready_o rises after edge NREGS; for NREGS = 32 it is high in cycle 32, counting the first post-reset edge as edge 1.
- clear_i in READY: ready_o drops the cycle after the edge that samples clear_i, and stays low for NREGS cycles.
- rst_i asserted mid-sweep or mid-operation: the state returns to CLEAR immediately (asynchronously), and the sweep restarts from 0 on deassertion.
- Reads are combinational and have zero latency.
- Write latency:
  - BYPASS = 0: written data is visible on reads from the cycle after the edge.
  - BYPASS = 1: written data is visible in the same cycle.
- Busy set/clear takes effect at the next edge.
- clr_cnt is AW+1 bits, so it does not wrap before reaching the terminal value NREGS-1.

## Test plan
- Reset sweep: deassert rst_i with NREGS = 32 → ready_o = 0 for 32 cycles, then 1. All 32 reads return 0. Writes issued during the sweep leave no effect.
- Write/read: write x5 = 64'hDEAD_BEEF_0123_4567, then read it on port 0 and port 1 the next cycle → both return that value. Write x0 = 64'hFFFF… → a read of x0 returns 0.
- Bypass: BYPASS = 1, write x7 = 64'h11 with port 1 reading x7 in the same cycle → 64'h11 that cycle. With BYPASS = 0 → the old value that cycle, 64'h11 the next.
- Scoreboard: issue x3 → read_busy_o = 1 from the next cycle. Then issue x3 and write x3 in the same cycle → still busy. Then write x3 alone → busy = 0 after the edge. Issue x0 → never busy.
- clear_i: after writing x1..x31 = their own index, pulse clear_i → ready_o is low for 32 cycles, all busy bits clear, and every register reads 0.
- Reset mid-sweep: assert rst_i at clr_cnt = 10 → outputs are immediately at reset values, and after deassertion ready_o returns only after a full 32-cycle sweep.
